// File: rtl/regfile_pkg.sv
// Shared types and defaults for the parametrised integer register file.
package regfile_pkg;

    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;
    localparam int AW_DEF   = 5;

    // Clear-sweep controller states.
    typedef enum logic [1:0] {
        CLR_IDLE  = 2'd0,
        CLR_SWEEP = 2'd1,
        CLR_DONE  = 2'd2
    } clr_state_t;

    // Minimum number of address bits needed to index n registers.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/regfile_clear_fsm.sv
// Clear-sweep controller: walks idx from 0 to NREG-1, one register per cycle,
// after reset release or on request, then pulses clear_done for one cycle.
//
// state     | meaning
// ----------+------------------------------------------------------------
// CLR_IDLE  | normal operation, waiting for clear_req
// CLR_SWEEP | zeroing reg[idx] each edge; writes/claims blocked
// CLR_DONE  | one-cycle completion pulse, array usable again
module regfile_clear_fsm
    import regfile_pkg::*;
#(
    parameter int NREG = NREG_DEF,
    parameter int AW   = AW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear_req,
    output logic          clear_busy,
    output logic          clear_done,
    output logic          sweep_we,
    output logic [AW-1:0] sweep_idx,
    output logic          sweep_start
);

    clr_state_t    state;
    clr_state_t    state_nxt;
    logic [AW-1:0] idx;
    logic [AW-1:0] idx_nxt;

    // State and sweep index registers; reset lands directly in a fresh sweep.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= CLR_SWEEP;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    // Next-state logic; clear_req is only honoured outside an active sweep.
    always_comb begin
        state_nxt   = state;
        idx_nxt     = idx;
        sweep_start = 1'b0;
        case (state)
            CLR_IDLE: begin
                if (clear_req) begin
                    state_nxt   = CLR_SWEEP;
                    idx_nxt     = '0;
                    sweep_start = 1'b1;
                end
            end
            CLR_SWEEP: begin
                if (32'(idx) == NREG - 1) begin
                    state_nxt = CLR_DONE;
                    idx_nxt   = '0;
                end else begin
                    idx_nxt = idx + AW'(1);
                end
            end
            CLR_DONE: begin
                if (clear_req) begin
                    state_nxt   = CLR_SWEEP;
                    idx_nxt     = '0;
                    sweep_start = 1'b1;
                end else begin
                    state_nxt = CLR_IDLE;
                end
            end
            default: begin
                state_nxt = CLR_IDLE;
                idx_nxt   = '0;
            end
        endcase
    end

    assign clear_busy = (state == CLR_SWEEP);
    assign clear_done = (state == CLR_DONE);
    assign sweep_we   = (state == CLR_SWEEP);
    assign sweep_idx  = idx;

endmodule

// File: rtl/register_file_param.sv
// Parametrised integer register file: two combinational read ports, one
// synchronous write port with optional same-cycle bypass, a per-register
// pending scoreboard for long-latency producers, and a hardware clear sweep.
module register_file_param
    import regfile_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int NREG     = NREG_DEF,
    parameter int AW       = AW_DEF,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            rs1_pending,
    output logic            rs2_pending,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [XLEN-1:0] wr_data,
    input  logic            claim_en,
    input  logic [AW-1:0]   claim_addr,
    input  logic            clear_req,
    output logic            clear_busy,
    output logic            clear_done
);

    // Reject parameter sets the address decode cannot represent.
    if (NREG < 2 || NREG > 256 || AW < clog2(NREG)) begin : g_param_err
        $error("register_file_param: NREG must be 2..256 and 2**AW >= NREG");
    end

    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] pending;

    logic            sweep_we;
    logic [AW-1:0]   sweep_idx;
    logic            sweep_start;
    logic            wr_legal;
    logic            claim_legal;

    // An address names a real, writable register (in range, not hardwired x0).
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return (32'(a) < NREG) && !((ZERO_REG != 0) && (a == AW'(0)));
    endfunction

    regfile_clear_fsm #(
        .NREG (NREG),
        .AW   (AW)
    ) u_clear_fsm (
        .clk         (clk),
        .reset       (reset),
        .clear_req   (clear_req),
        .clear_busy  (clear_busy),
        .clear_done  (clear_done),
        .sweep_we    (sweep_we),
        .sweep_idx   (sweep_idx),
        .sweep_start (sweep_start)
    );

    assign wr_legal    = wr_en    && !clear_busy && addr_ok(wr_addr);
    assign claim_legal = claim_en && !clear_busy && addr_ok(claim_addr);

    // Storage array: the sweep owns the write port while busy; no reset so the
    // array maps onto plain storage and is zeroed by the sweep instead.
    always_ff @(posedge clk) begin
        if (sweep_we) begin
            regs[sweep_idx] <= '0;
        end else if (wr_legal) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Scoreboard: a write retires the producer, a claim issued on the same
    // edge is applied last so the newer producer keeps the register pending.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= '0;
        end else if (sweep_start) begin
            pending <= '0;
        end else begin
            if (wr_legal) pending[wr_addr] <= 1'b0;
            if (claim_legal) pending[claim_addr] <= 1'b1;
        end
    end

    // Read port 1: forced zero while sweeping or for x0/out-of-range addresses.
    always_comb begin
        rs1_data    = '0;
        rs1_pending = 1'b0;
        if (!clear_busy && addr_ok(rs1_addr)) begin
            if ((BYPASS != 0) && wr_legal && (wr_addr == rs1_addr)) begin
                rs1_data = wr_data;
            end else begin
                rs1_data    = regs[rs1_addr];
                rs1_pending = pending[rs1_addr];
            end
        end
    end

    // Read port 2: same resolution as port 1, independently addressed.
    always_comb begin
        rs2_data    = '0;
        rs2_pending = 1'b0;
        if (!clear_busy && addr_ok(rs2_addr)) begin
            if ((BYPASS != 0) && wr_legal && (wr_addr == rs2_addr)) begin
                rs2_data = wr_data;
            end else begin
                rs2_data    = regs[rs2_addr];
                rs2_pending = pending[rs2_addr];
            end
        end
    end

endmodule

// File: tb/tb_register_file_param.sv
// Bench for register_file_param: three instances share stimulus
// (default, no-bypass, NREG=20) and are compared against an array model.
module tb_register_file_param;

    logic        clk;
    logic        reset;
    logic [4:0]  rs1_addr, rs2_addr, wr_addr, claim_addr;
    logic [31:0] wr_data;
    logic        wr_en, claim_en, clear_req;

    logic [31:0] rs1_d [3];
    logic [31:0] rs2_d [3];
    logic        rs1_p [3];
    logic        rs2_p [3];
    logic        busy  [3];
    logic        done  [3];

    int errors = 0;
    int checks = 0;

    // Reference model state per instance
    int          nreg_m [3] = '{32, 32, 20};
    bit          byp_m  [3] = '{1'b1, 1'b0, 1'b1};
    logic [31:0] mem_m  [3][32];
    bit          pend_m [3][32];
    int          cnt_m  [3];
    bit          done_m [3];

    register_file_param dut0 (
        .clk(clk), .reset(reset), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_d[0]), .rs2_data(rs2_d[0]), .rs1_pending(rs1_p[0]), .rs2_pending(rs2_p[0]),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .claim_en(claim_en),
        .claim_addr(claim_addr), .clear_req(clear_req), .clear_busy(busy[0]), .clear_done(done[0]));

    register_file_param #(.BYPASS(0)) dut1 (
        .clk(clk), .reset(reset), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_d[1]), .rs2_data(rs2_d[1]), .rs1_pending(rs1_p[1]), .rs2_pending(rs2_p[1]),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .claim_en(claim_en),
        .claim_addr(claim_addr), .clear_req(clear_req), .clear_busy(busy[1]), .clear_done(done[1]));

    register_file_param #(.NREG(20), .AW(5)) dut2 (
        .clk(clk), .reset(reset), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_d[2]), .rs2_data(rs2_d[2]), .rs1_pending(rs1_p[2]), .rs2_pending(rs2_p[2]),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .claim_en(claim_en),
        .claim_addr(claim_addr), .clear_req(clear_req), .clear_busy(busy[2]), .clear_done(done[2]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    function automatic bit legal(int i, logic [4:0] a);
        return (int'(a) < nreg_m[i]) && (a != 5'd0);
    endfunction

    function automatic logic [31:0] exp_data(int i, logic [4:0] a);
        if (cnt_m[i] > 0 || !legal(i, a)) return 32'h0;
        if (byp_m[i] && wr_en && wr_addr == a && legal(i, wr_addr)) return wr_data;
        return mem_m[i][a];
    endfunction

    function automatic bit exp_pend(int i, logic [4:0] a);
        if (cnt_m[i] > 0 || !legal(i, a)) return 1'b0;
        if (byp_m[i] && wr_en && wr_addr == a && legal(i, wr_addr)) return 1'b0;
        return pend_m[i][a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            cnt_m[i]  = nreg_m[i];
            done_m[i] = 1'b0;
            for (int j = 0; j < 32; j++) pend_m[i][j] = 1'b0;
        end
    endtask

    // Apply one clock edge of the specified behaviour to the model.
    task automatic model_edge();
        for (int i = 0; i < 3; i++) begin
            if (reset) begin
                cnt_m[i]  = nreg_m[i];
                done_m[i] = 1'b0;
                for (int j = 0; j < 32; j++) pend_m[i][j] = 1'b0;
            end else if (cnt_m[i] > 0) begin
                mem_m[i][nreg_m[i] - cnt_m[i]] = 32'h0;
                cnt_m[i]  = cnt_m[i] - 1;
                done_m[i] = (cnt_m[i] == 0);
            end else begin
                done_m[i] = 1'b0;
                if (wr_en && legal(i, wr_addr)) begin
                    mem_m[i][wr_addr]  = wr_data;
                    pend_m[i][wr_addr] = 1'b0;
                end
                if (claim_en && legal(i, claim_addr)) pend_m[i][claim_addr] = 1'b1;
                if (clear_req) begin
                    cnt_m[i] = nreg_m[i];
                    for (int j = 0; j < 32; j++) pend_m[i][j] = 1'b0;
                end
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        wr_en = 1'b0; claim_en = 1'b0; clear_req = 1'b0;
    endtask

    task automatic test_reset();
        int first_idle [3];
        int pulses [3];
        reset = 1'b1;
        model_reset();
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (busy[i] !== 1'b1 || done[i] !== 1'b0) begin
                errors++;
                $display("FAIL reset_flags dut%0d busy=%b done=%b required busy=1 done=0", i, busy[i], done[i]);
            end
        end
        cycle(); cycle();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin first_idle[i] = -1; pulses[i] = 0; end
        for (int k = 1; k <= 40; k++) begin
            cycle();
            for (int i = 0; i < 3; i++) begin
                if (done[i] === 1'b1) pulses[i]++;
                if (busy[i] === 1'b0 && first_idle[i] < 0) first_idle[i] = k;
                checks++;
                if (busy[i] !== (cnt_m[i] > 0) || done[i] !== done_m[i]) begin
                    errors++;
                    $display("FAIL reset_sweep dut%0d cyc%0d busy=%b done=%b required busy=%b done=%b",
                             i, k, busy[i], done[i], cnt_m[i] > 0, done_m[i]);
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (first_idle[i] != nreg_m[i] || pulses[i] != 1) begin
                errors++;
                $display("FAIL reset_len dut%0d cycles=%0d pulses=%0d required cycles=%0d pulses=1",
                         i, first_idle[i], pulses[i], nreg_m[i]);
            end
        end
        for (int a = 0; a < 32; a++) begin
            rs1_addr = 5'(a);
            rs2_addr = 5'(31 - a);
            #1;
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (rs1_d[i] !== 32'h0 || rs2_d[i] !== 32'h0 || rs1_p[i] !== 1'b0 || rs2_p[i] !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_zero dut%0d addr=%0d d1=%h d2=%h p1=%b p2=%b required all zero",
                             i, a, rs1_d[i], rs2_d[i], rs1_p[i], rs2_p[i]);
                end
            end
            cycle();
        end
    endtask

    task automatic test_bypass();
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF; rs1_addr = 5'd5;
        #1;
        checks++;
        if (rs1_d[0] !== 32'hDEADBEEF || rs1_d[2] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL bypass_same dut0=%h dut2=%h required deadbeef", rs1_d[0], rs1_d[2]);
        end
        checks++;
        if (rs1_d[1] !== 32'h0) begin
            errors++;
            $display("FAIL nobypass_old got=%h required 00000000", rs1_d[1]);
        end
        cycle();
        idle_inputs();
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (rs1_d[i] !== 32'hDEADBEEF) begin
                errors++;
                $display("FAIL write_next dut%0d got=%h required deadbeef", i, rs1_d[i]);
            end
        end
        cycle();
    endtask

    task automatic test_zero_reg();
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234;
        claim_en = 1'b1; claim_addr = 5'd0; rs1_addr = 5'd0;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (rs1_d[i] !== 32'h0 || rs1_p[i] !== 1'b0) begin
                errors++;
                $display("FAIL x0_same dut%0d data=%h pend=%b required 0/0", i, rs1_d[i], rs1_p[i]);
            end
        end
        cycle();
        idle_inputs();
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (rs1_d[i] !== 32'h0 || rs1_p[i] !== 1'b0) begin
                errors++;
                $display("FAIL x0_after dut%0d data=%h pend=%b required 0/0", i, rs1_d[i], rs1_p[i]);
            end
        end
        cycle();
    endtask

    task automatic test_scoreboard();
        rs2_addr = 5'd7;
        claim_en = 1'b1; claim_addr = 5'd7;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (rs2_p[i] !== 1'b0) begin
                errors++;
                $display("FAIL claim_early dut%0d pend=%b required 0", i, rs2_p[i]);
            end
        end
        cycle();
        idle_inputs();
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (rs2_p[i] !== 1'b1) begin
                errors++;
                $display("FAIL claim_vis dut%0d pend=%b required 1", i, rs2_p[i]);
            end
        end
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'd42;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (rs2_p[i] !== exp_pend(i, 5'd7) || rs2_d[i] !== exp_data(i, 5'd7)) begin
                errors++;
                $display("FAIL write_clr_same dut%0d data=%h pend=%b required %h/%b",
                         i, rs2_d[i], rs2_p[i], exp_data(i, 5'd7), exp_pend(i, 5'd7));
            end
        end
        cycle();
        idle_inputs();
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (rs2_p[i] !== 1'b0 || rs2_d[i] !== 32'd42) begin
                errors++;
                $display("FAIL write_clr dut%0d data=%h pend=%b required 2a/0", i, rs2_d[i], rs2_p[i]);
            end
        end
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'd42;
        claim_en = 1'b1; claim_addr = 5'd7;
        cycle();
        idle_inputs();
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (rs2_p[i] !== 1'b1 || rs2_d[i] !== 32'd42) begin
                errors++;
                $display("FAIL write_claim dut%0d data=%h pend=%b required 2a/1", i, rs2_d[i], rs2_p[i]);
            end
        end
        cycle();
    endtask

    task automatic test_back_to_back();
        wr_en = 1'b1; wr_addr = 5'd10; wr_data = 32'hA5A5_0010;
        cycle();
        wr_addr = 5'd11; wr_data = 32'h5A5A_0011;
        rs1_addr = 5'd10; rs2_addr = 5'd11;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (rs1_d[i] !== exp_data(i, 5'd10) || rs2_d[i] !== exp_data(i, 5'd11)) begin
                errors++;
                $display("FAIL b2b dut%0d d1=%h d2=%h required %h/%h",
                         i, rs1_d[i], rs2_d[i], exp_data(i, 5'd10), exp_data(i, 5'd11));
            end
        end
        cycle();
        idle_inputs();
    endtask

    task automatic test_range();
        wr_en = 1'b1; wr_addr = 5'd25; wr_data = 32'hCAFE;
        claim_en = 1'b1; claim_addr = 5'd25; rs1_addr = 5'd25; rs2_addr = 5'd19;
        #1;
        checks++;
        if (rs1_d[2] !== 32'h0 || rs1_p[2] !== 1'b0) begin
            errors++;
            $display("FAIL range_same data=%h pend=%b required 0/0", rs1_d[2], rs1_p[2]);
        end
        cycle();
        wr_addr = 5'd19; wr_data = 32'h1919; claim_en = 1'b0;
        cycle();
        idle_inputs();
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (rs1_d[i] !== exp_data(i, 5'd25) || rs1_p[i] !== exp_pend(i, 5'd25) ||
                rs2_d[i] !== exp_data(i, 5'd19)) begin
                errors++;
                $display("FAIL range dut%0d d25=%h p25=%b d19=%h required %h/%b/%h", i,
                         rs1_d[i], rs1_p[i], rs2_d[i], exp_data(i, 5'd25), exp_pend(i, 5'd25), exp_data(i, 5'd19));
            end
        end
        checks++;
        if (rs1_d[2] !== 32'h0 || rs2_d[2] !== 32'h1919) begin
            errors++;
            $display("FAIL range_n20 d25=%h d19=%h required 0/1919", rs1_d[2], rs2_d[2]);
        end
        cycle();
    endtask

    task automatic test_clear_req();
        int first_idle [3];
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h99;
        claim_en = 1'b1; claim_addr = 5'd3;
        cycle();
        idle_inputs();
        clear_req = 1'b1;
        cycle();
        for (int i = 0; i < 3; i++) first_idle[i] = -1;
        for (int k = 1; k <= 40; k++) begin
            clear_req = (k == 10);
            cycle();
            for (int i = 0; i < 3; i++)
                if (busy[i] === 1'b0 && first_idle[i] < 0) first_idle[i] = k;
        end
        clear_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (first_idle[i] != nreg_m[i]) begin
                errors++;
                $display("FAIL clear_len dut%0d cycles=%0d required %0d", i, first_idle[i], nreg_m[i]);
            end
        end
        rs1_addr = 5'd9; rs2_addr = 5'd3;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (rs1_d[i] !== 32'h0 || rs2_p[i] !== 1'b0) begin
                errors++;
                $display("FAIL clear_zero dut%0d x9=%h p3=%b required 0/0", i, rs1_d[i], rs2_p[i]);
            end
        end
        clear_req = 1'b1;
        cycle();
        clear_req = 1'b0;
        repeat (10) cycle();
        reset = 1'b1;
        model_reset();
        cycle();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) first_idle[i] = -1;
        for (int k = 1; k <= 40; k++) begin
            cycle();
            for (int i = 0; i < 3; i++)
                if (busy[i] === 1'b0 && first_idle[i] < 0) first_idle[i] = k;
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (first_idle[i] != nreg_m[i]) begin
                errors++;
                $display("FAIL midsweep_reset dut%0d cycles=%0d required %0d", i, first_idle[i], nreg_m[i]);
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            wr_en      = ($urandom_range(0, 1) == 1);
            wr_addr    = 5'($urandom_range(0, 31));
            wr_data    = $urandom;
            claim_en   = ($urandom_range(0, 2) == 0);
            claim_addr = ($urandom_range(0, 2) == 0) ? wr_addr : 5'($urandom_range(0, 31));
            rs1_addr   = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 31));
            rs2_addr   = ($urandom_range(0, 3) == 0) ? rs1_addr : 5'($urandom_range(0, 31));
            clear_req  = ($urandom_range(0, 99) == 0);
            #1;
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (rs1_d[i] !== exp_data(i, rs1_addr) || rs2_d[i] !== exp_data(i, rs2_addr) ||
                    rs1_p[i] !== exp_pend(i, rs1_addr) || rs2_p[i] !== exp_pend(i, rs2_addr) ||
                    busy[i] !== (cnt_m[i] > 0) || done[i] !== done_m[i]) begin
                    errors++;
                    $display("FAIL random dut%0d n=%0d d1=%h/%h d2=%h/%h p1=%b/%b p2=%b/%b busy=%b/%b done=%b/%b (got/required)",
                             i, n, rs1_d[i], exp_data(i, rs1_addr), rs2_d[i], exp_data(i, rs2_addr),
                             rs1_p[i], exp_pend(i, rs1_addr), rs2_p[i], exp_pend(i, rs2_addr),
                             busy[i], cnt_m[i] > 0, done[i], done_m[i]);
                end
            end
            cycle();
        end
        idle_inputs();
    endtask

    initial begin
        reset = 1'b1;
        rs1_addr = '0; rs2_addr = '0; wr_addr = '0; claim_addr = '0; wr_data = '0;
        idle_inputs();
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 32; j++) mem_m[i][j] = 32'h0;
        model_reset();
        test_reset();
        test_bypass();
        test_zero_reg();
        test_scoreboard();
        test_back_to_back();
        test_range();
        test_clear_req();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
